// File: rtl/mul_div_unit_if.sv
// Issue/result handshake bundle between the decoder, the M-extension unit
// and the writeback arbiter.
interface mul_div_unit_if #(
    parameter int TAG_W = 5
);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [3:0]        op_i;
    logic [63:0]       rs1_i;
    logic [63:0]       rs2_i;
    logic [TAG_W-1:0]  tag_i;
    logic              result_valid_o;
    logic              result_ready_i;
    logic [63:0]       result_o;
    logic [TAG_W-1:0]  tag_o;

    modport master (
        output flush_i, valid_i, op_i, rs1_i, rs2_i, tag_i, result_ready_i,
        input  ready_o, result_valid_o, result_o, tag_o
    );

    modport slave (
        input  flush_i, valid_i, op_i, rs1_i, rs2_i, tag_i, result_ready_i,
        output ready_o, result_valid_o, result_o, tag_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: 64-step shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up applied in DONE.
package riscv_pkg;
    typedef enum logic [3:0] {
        M_NONE   = 4'd0,
        M_MUL    = 4'd1,
        M_MULH   = 4'd2,
        M_MULHSU = 4'd3,
        M_MULHU  = 4'd4,
        M_DIV    = 4'd5,
        M_DIVU   = 4'd6,
        M_REM    = 4'd7,
        M_REMU   = 4'd8
    } mul_op_t;
endpackage

module mul_div_unit #(
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);
    import riscv_pkg::*;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [5:0]         cnt;
    logic [3:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               neg_a_q, neg_b_q, fast_q;
    logic [63:0]        opnd_q;
    logic [127:0]       p;

    logic               accept;
    logic               a_signed, b_signed, is_mul, is_div, is_mul_q;
    logic               neg_a, neg_b, div_zero, sgn_ovf, fast;
    logic [63:0]        mag_a, mag_b, fast_val;
    logic [127:0]       p_step;
    logic [64:0]        mul_sum, rem_sh;
    logic [127:0]       prod;
    logic [63:0]        quo, rem, res_sel;

    assign accept = bus.valid_i && (state == IDLE) && !bus.flush_i;

    // Issue-side decode, operand magnitudes and fast-path detection.
    always_comb begin
        a_signed = bus.op_i inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM};
        b_signed = bus.op_i inside {M_MUL, M_MULH, M_DIV, M_REM};
        is_mul   = bus.op_i inside {M_MUL, M_MULH, M_MULHSU, M_MULHU};
        is_div   = bus.op_i inside {M_DIV, M_DIVU, M_REM, M_REMU};
        neg_a    = a_signed && bus.rs1_i[63];
        neg_b    = b_signed && bus.rs2_i[63];
        mag_a    = neg_a ? -bus.rs1_i : bus.rs1_i;
        mag_b    = neg_b ? -bus.rs2_i : bus.rs2_i;
        div_zero = is_div && (bus.rs2_i == '0);
        sgn_ovf  = (bus.op_i inside {M_DIV, M_REM}) &&
                   (bus.rs1_i == 64'h8000_0000_0000_0000) && (bus.rs2_i == '1);
        fast     = div_zero || sgn_ovf || !(is_mul || is_div);
        fast_val = '0;
        if (div_zero)
            fast_val = (bus.op_i inside {M_DIV, M_DIVU}) ? '1 : bus.rs1_i;
        else if (sgn_ovf && bus.op_i == M_DIV)
            fast_val = 64'h8000_0000_0000_0000;
    end

    // One iteration: multiply shifts the multiplier out of p[63:0] while the
    // partial sum enters at the top; divide shifts the dividend in from p[63].
    always_comb begin
        is_mul_q = op_q inside {M_MUL, M_MULH, M_MULHSU, M_MULHU};
        mul_sum  = {1'b0, p[127:64]} + (p[0] ? {1'b0, opnd_q} : 65'd0);
        rem_sh   = {p[127:64], p[63]};
        if (is_mul_q)
            p_step = {mul_sum, p[63:1]};
        else if (rem_sh >= {1'b0, opnd_q})
            p_step = {rem_sh[63:0] - opnd_q, p[62:0], 1'b1};
        else
            p_step = {rem_sh[63:0], p[62:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = fast ? DONE : CALC;
            CALC: if (cnt == 6'd63) state_nxt = DONE;
            DONE: if (bus.result_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush_i)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            fast_q  <= 1'b0;
            opnd_q  <= '0;
            p       <= '0;
        end else if (bus.flush_i) begin
            cnt <= '0;
        end else if (accept) begin
            cnt     <= '0;
            op_q    <= bus.op_i;
            tag_q   <= bus.tag_i;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            fast_q  <= fast;
            opnd_q  <= is_mul ? mag_a : mag_b;
            p       <= fast ? {64'd0, fast_val} : {64'd0, (is_mul ? mag_b : mag_a)};
        end else if (state == CALC) begin
            cnt <= cnt + 6'd1;
            p   <= p_step;
        end
    end

    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -p : p;
        quo  = (neg_a_q ^ neg_b_q) ? -p[63:0] : p[63:0];
        rem  = neg_a_q ? -p[127:64] : p[127:64];
        case (op_q)
            M_MUL:                     res_sel = prod[63:0];
            M_MULH, M_MULHSU, M_MULHU: res_sel = prod[127:64];
            M_DIV, M_DIVU:             res_sel = quo;
            M_REM, M_REMU:             res_sel = rem;
            default:                   res_sel = '0;
        endcase
    end

    assign bus.ready_o        = (state == IDLE);
    assign bus.result_valid_o = (state == DONE);
    assign bus.result_o       = (state == DONE) ? (fast_q ? p[63:0] : res_sel) : '0;
    assign bus.tag_o          = (state == DONE) ? tag_q : '0;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus flush, reset and
// backpressure sequences.
module tb_mul_div_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_div_unit_if #(.TAG_W(5)) bus();
    mul_div_unit #(.TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // lat = posedges after the accept edge until result_valid_o is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.result_valid_o && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        bus.tag_i   = tag;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic take_result(input string name);
        bus.result_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.result_ready_i = 1'b0;
        chk({name, "_ready_after"}, {63'd0, bus.ready_o}, 64'd1);
        chk({name, "_valid_after"}, {63'd0, bus.result_valid_o}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.op, v.a, v.b, v.tag);
        wait_valid(lat);
        chk({v.name, "_lat"}, 64'(lat), 64'(v.lat));
        chk({v.name, "_res"}, bus.result_o, v.exp);
        chk({v.name, "_tag"}, {59'd0, bus.tag_o}, {59'd0, v.tag});
        take_result(v.name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int bad;
        logic [63:0] hold_res;

        bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.op_i = '0;
        bus.rs1_i = '0; bus.rs2_i = '0; bus.tag_i = '0; bus.result_ready_i = 1'b0;

        vecs.push_back('{M_MUL,    64'hFFFF_FFFF_FFFF_FFFD, 64'd7,                   5'd3,  64'hFFFF_FFFF_FFFF_FFEB, 64, "mul_neg"});
        vecs.push_back('{M_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4,  64'd0,                  64, "mulh_m1"});
        vecs.push_back('{M_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64, "mulhsu_m1"});
        vecs.push_back('{M_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,  64'hFFFF_FFFF_FFFF_FFFE, 64, "mulhu_max"});
        vecs.push_back('{M_MUL,    64'h1_0000_0001,         64'h1_0000_0001,         5'd7,  64'h0000_0002_0000_0001, 64, "mul_big"});
        vecs.push_back('{M_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   5'd8,  64'd1,                  64, "mulhu_x2"});
        vecs.push_back('{M_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   5'd9,  64'hFFFF_FFFF_FFFF_FFFD, 64, "div_m7_2"});
        vecs.push_back('{M_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64, "rem_m7_2"});
        vecs.push_back('{M_DIV,    64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 64, "div_7_m2"});
        vecs.push_back('{M_REM,    64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 5'd12, 64'd1,                  64, "rem_7_m2"});
        vecs.push_back('{M_DIVU,   64'd100,                 64'd7,                   5'd13, 64'd14,                 64, "divu_100_7"});
        vecs.push_back('{M_REMU,   64'd100,                 64'd7,                   5'd14, 64'd2,                  64, "remu_100_7"});
        vecs.push_back('{M_DIVU,   64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000,         5'd15, 64'h0000_0000_FFFF_FFFF, 64, "divu_big"});
        vecs.push_back('{M_DIV,    64'h8000_0000_0000_0000, 64'd2,                   5'd16, 64'hC000_0000_0000_0000, 64, "div_min_2"});
        vecs.push_back('{M_DIVU,   64'd123,                 64'd0,                   5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 0,  "divu_by0"});
        vecs.push_back('{M_REM,    64'd5,                   64'd0,                   5'd18, 64'd5,                  0,  "rem_by0"});
        vecs.push_back('{M_REMU,   64'hDEAD_BEEF,           64'd0,                   5'd19, 64'hDEAD_BEEF,          0,  "remu_by0"});
        vecs.push_back('{M_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd20, 64'h8000_0000_0000_0000, 0, "div_ovf"});
        vecs.push_back('{M_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd21, 64'd0,                  0, "rem_ovf"});
        vecs.push_back('{M_NONE,   64'd9,                   64'd9,                   5'd22, 64'd0,                  0,  "op_none"});
        vecs.push_back('{4'd15,    64'd9,                   64'd9,                   5'd23, 64'd0,                  0,  "op_undef"});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  {63'd0, bus.result_valid_o}, 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        chk("rst_tag",    {59'd0, bus.tag_o}, 64'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rst_ready", {63'd0, bus.ready_o}, 64'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result and tag held while the consumer stalls.
        issue(M_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd25);
        wait_valid(lat);
        chk("bp_lat", 64'(lat), 64'd64);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.result_o !== 64'hFFFF_FFFF_FFFF_FFFE || bus.tag_o !== 5'd25 ||
                bus.ready_o !== 1'b0 || bus.result_valid_o !== 1'b1) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        take_result("bp");

        // Flush at iteration 30: no result, next op unaffected.
        issue(M_MUL, 64'd1234, 64'd5678, 5'd26);
        repeat (29) @(posedge clk);
        @(negedge clk) bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk("flush_ready", {63'd0, bus.ready_o}, 64'd1);
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (bus.result_valid_o) bad++;
        end
        chk("flush_no_result", 64'(bad), 64'd0);
        run_vec('{M_DIVU, 64'd1000, 64'd33, 5'd27, 64'd30, 64, "post_flush"});

        // Flush wins over the DONE handshake and a simultaneous request.
        issue(M_DIVU, 64'd8, 64'd0, 5'd28);
        @(negedge clk);
        bus.flush_i = 1'b1; bus.valid_i = 1'b1; bus.result_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("flush_done_idle", {63'd0, bus.ready_o}, 64'd1);
        @(posedge clk); #1;
        bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.result_ready_i = 1'b0;
        chk("flush_no_accept", {63'd0, bus.ready_o}, 64'd1);

        // Asynchronous reset mid-CALC.
        issue(M_DIV, 64'd77, 64'd3, 5'd29);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_calc_valid", {63'd0, bus.result_valid_o}, 64'd0);
        chk("arst_calc_ready", {63'd0, bus.ready_o}, 64'd1);
        @(negedge clk) rst = 1'b0;

        // Asynchronous reset while a result is pending in DONE.
        issue(M_REMU, 64'd100, 64'd7, 5'd30);
        wait_valid(lat);
        hold_res = bus.result_o;
        chk("arst_pre_res", hold_res, 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_done_valid",  {63'd0, bus.result_valid_o}, 64'd0);
        chk("arst_done_result", bus.result_o, 64'd0);
        chk("arst_done_tag",    {59'd0, bus.tag_o}, 64'd0);
        @(negedge clk) rst = 1'b0;
        run_vec('{M_MUL, 64'd6, 64'd7, 5'd31, 64'd42, 64, "post_rst"});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
